regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, default 32: data width of every register and data port, in bits.
REQ-002 Parameter NREGS, default 32: architectural register count including x0; power of two, 4 to 64.
REQ-003 Parameter SP_INDEX, default 2: index of the stack-pointer register; 1 <= SP_INDEX < NREGS.
REQ-004 Parameter SP_INIT, default 32'h0100_0000: value loaded into register SP_INDEX during init.
REQ-005 Derived AW = clog2(NREGS): width of every address port.
REQ-006 clock  in  1  single clock; all state updates on the rising edge.
REQ-007 reset_n  in  1  reset, synchronous, active-low.
REQ-008 ready  out  1  high when init is done and the file accepts writes and reservations.
REQ-009 addr_rs1 / addr_rs2  in  AW  read addresses.
REQ-010 data_rs1 / data_rs2  out  XLEN  combinational read data.
REQ-011 busy_rs1 / busy_rs2  out  1  combinational; the addressed register has a pending producer.
REQ-012 addr_rd  in  AW, data_rd  in  XLEN, write_enable  in  1: writeback port.
REQ-013 reserve_en  in  1, reserve_addr  in  AW: decode-stage reservation of a future destination.

Function
REQ-014 State machine SHALL have two states, INIT and RUN, plus an internal init index idx of AW bits.
- INIT: each cycle writes idx with SP_INIT if idx == SP_INDEX, else 0; then idx increments.
- INIT -> RUN on the edge that writes idx == NREGS-1; ready goes to 1 on that same edge.
- RUN: no transition except on reset.
REQ-015 Init SHALL take exactly NREGS-1 cycles (idx runs 1 to NREGS-1).
REQ-016 x0 SHALL have no storage; reads of address 0 return 0 and busy 0 in every state.
REQ-017 In RUN, when write_enable = 1 and addr_rd != 0, register addr_rd SHALL load data_rd at the rising edge.
- Writes to address 0 are discarded.
REQ-018 Read bypass: in RUN, when write_enable = 1, addr_rd != 0 and addr_rsN == addr_rd, data_rsN SHALL equal data_rd in the same cycle.
REQ-019 Scoreboard: one pending bit per register 1..NREGS-1, held in flops.
REQ-020 In RUN, a write with addr_rd != 0 SHALL clear pending[addr_rd] at the edge.
REQ-021 In RUN, reserve_en = 1 with reserve_addr != 0 SHALL set pending[reserve_addr] at the edge.
REQ-022 When a reservation and a write target the same address in the same cycle, set SHALL win (the newer producer) and the data is still written.
REQ-023 busy_rsN SHALL equal pending[addr_rsN] AND NOT (write_enable AND addr_rd == addr_rsN), so a same-cycle writeback hides busy together with the bypass.
REQ-024 While ready = 0: data_rs1, data_rs2, busy_rs1 and busy_rs2 SHALL be 0, and write_enable and reserve_en SHALL be ignored.
REQ-025 Reads SHALL have no side effects; both read ports are independent and may address the same register.

Reset
REQ-026 At any rising edge with reset_n = 0, including mid-init and mid-RUN:
- state <= INIT, idx <= 1, ready <= 0, all pending bits <= 0.
- Register contents are then rebuilt by the init sequence.
REQ-027 Init SHALL begin on the first edge with reset_n = 1 after reset.
REQ-028 No other reset value SHALL exist; there are no asynchronous paths.

Verification
REQ-029 Init (defaults): release reset -> ready rises after exactly 31 cycles. Then read x2 -> 32'h0100_0000; x1, x3 and x31 -> 0; all busy = 0.
REQ-030 Write/bypass: in RUN, write x5 = 32'hDEAD_BEEF with addr_rs1 = 5 in the same cycle -> data_rs1 = DEAD_BEEF that cycle, and x5 holds it on the next cycle. Write x0 = 32'h1234 -> x0 still reads 0.
REQ-031 Scoreboard:
- reserve x7 -> busy_rs2 = 1 for addr_rs2 = 7 from the next cycle.
- write x7 = 9 -> busy_rs2 = 0 and data_rs2 = 9 in the write cycle.
- pending[7] = 0 afterwards.
REQ-032 Collision: reserve x7 and write x7 = 3 in the same cycle -> next cycle x7 reads 3 and busy = 1.
REQ-033 Reset mid-RUN: with x7 pending and x5 = DEAD_BEEF, pulse reset_n low for one edge.
- ready = 0 next cycle; during init, data and busy outputs = 0 and a write attempt has no effect.
- After 31 cycles, x5 = 0, busy = 0, x2 = SP_INIT.
REQ-034 Parameter sweep with NREGS = 8, XLEN = 64, SP_INDEX = 3 -> init takes 7 cycles, x3 = SP_INIT, and all 64 data bits write and read back.

Source files
------------

// File: rtl/regfile_sb.sv
// Integer register file with hardwired x0, SP preload on init,
// write-through read bypass and a per-register pending scoreboard.
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int SP_INDEX = 2,
  parameter logic [XLEN-1:0] SP_INIT = 32'h0100_0000,
  localparam int AW = $clog2(NREGS)
) (
  input  logic            clock,
  input  logic            reset_n,
  output logic            ready,
  input  logic [AW-1:0]   addr_rs1,
  input  logic [AW-1:0]   addr_rs2,
  output logic [XLEN-1:0] data_rs1,
  output logic [XLEN-1:0] data_rs2,
  output logic            busy_rs1,
  output logic            busy_rs2,
  input  logic [AW-1:0]   addr_rd,
  input  logic [XLEN-1:0] data_rd,
  input  logic            write_enable,
  input  logic            reserve_en,
  input  logic [AW-1:0]   reserve_addr
);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_e;

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);
  localparam logic [AW-1:0] SPA  = AW'(SP_INDEX);

  state_e            state_q;
  logic [AW-1:0]     idx_q;
  logic              ready_q;
  logic [NREGS-1:0]  pend_q;
  logic [NREGS-1:0]  pend_d;
  logic [XLEN-1:0]   regs_q [1:NREGS-1];

  logic              wen_run;
  logic              rsv_run;
  logic              w_en;
  logic [AW-1:0]     w_addr;
  logic [XLEN-1:0]   w_data;

  assign ready   = ready_q;
  assign wen_run = ready_q && write_enable && (addr_rd != '0);
  assign rsv_run = ready_q && reserve_en && (reserve_addr != '0);

  // Reservation is applied after the clear so the newer producer wins.
  always_comb begin
    pend_d = pend_q;
    if (wen_run) pend_d[addr_rd] = 1'b0;
    if (rsv_run) pend_d[reserve_addr] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_comb begin
    w_en   = 1'b0;
    w_addr = addr_rd;
    w_data = data_rd;
    if (reset_n) begin
      if (state_q == S_INIT) begin
        w_en   = 1'b1;
        w_addr = idx_q;
        w_data = (idx_q == SPA) ? SP_INIT : '0;
      end else begin
        w_en = wen_run;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_INIT;
      idx_q   <= AW'(1);
      ready_q <= 1'b0;
      pend_q  <= '0;
    end else begin
      pend_q <= pend_d;
      unique case (state_q)
        S_INIT: begin
          idx_q <= idx_q + 1'b1;
          if (idx_q == LAST) begin
            state_q <= S_RUN;
            ready_q <= 1'b1;
          end
        end
        S_RUN: begin
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_en) regs_q[w_addr] <= w_data;
  end

  always_comb begin
    data_rs1 = '0;
    if (ready_q && addr_rs1 != '0)
      data_rs1 = (wen_run && addr_rd == addr_rs1) ? data_rd
                                                  : regs_q[addr_rs1];
  end

  always_comb begin
    data_rs2 = '0;
    if (ready_q && addr_rs2 != '0)
      data_rs2 = (wen_run && addr_rd == addr_rs2) ? data_rd
                                                  : regs_q[addr_rs2];
  end

  assign busy_rs1 = ready_q && (addr_rs1 != '0) && pend_q[addr_rs1]
                    && !(write_enable && addr_rd == addr_rs1);
  assign busy_rs2 = ready_q && (addr_rs2 != '0) && pend_q[addr_rs2]
                    && !(write_enable && addr_rd == addr_rs2);

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default instance plus a
// narrow/wide instance (NREGS=8, XLEN=64, SP_INDEX=3).
module tb_regfile_sb;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic        a_ready, a_busy1, a_busy2, a_we, a_rsv;
  logic [4:0]  a_rs1, a_rs2, a_rd, a_raddr;
  logic [31:0] a_d1, a_d2, a_wd;

  logic        b_ready, b_busy1, b_busy2, b_we, b_rsv;
  logic [2:0]  b_rs1, b_rs2, b_rd, b_raddr;
  logic [63:0] b_d1, b_d2, b_wd;

  regfile_sb u_a (
    .clock(clock), .reset_n(reset_n), .ready(a_ready),
    .addr_rs1(a_rs1), .addr_rs2(a_rs2),
    .data_rs1(a_d1), .data_rs2(a_d2),
    .busy_rs1(a_busy1), .busy_rs2(a_busy2),
    .addr_rd(a_rd), .data_rd(a_wd), .write_enable(a_we),
    .reserve_en(a_rsv), .reserve_addr(a_raddr)
  );

  regfile_sb #(.XLEN(64), .NREGS(8), .SP_INDEX(3)) u_b (
    .clock(clock), .reset_n(reset_n), .ready(b_ready),
    .addr_rs1(b_rs1), .addr_rs2(b_rs2),
    .data_rs1(b_d1), .data_rs2(b_d2),
    .busy_rs1(b_busy1), .busy_rs2(b_busy2),
    .addr_rd(b_rd), .data_rd(b_wd), .write_enable(b_we),
    .reserve_en(b_rsv), .reserve_addr(b_raddr)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  int cnt_a;
  int cnt_b;

  task automatic run_init();
    cnt_a = 0;
    cnt_b = 0;
    while (!a_ready && cnt_a < 40) begin
      step();
      cnt_a++;
      if (b_ready && cnt_b == 0) cnt_b = cnt_a;
    end
  endtask

  initial begin
    a_rs1 = '0; a_rs2 = '0; a_rd = '0; a_wd = '0;
    a_we = 1'b0; a_rsv = 1'b0; a_raddr = '0;
    b_rs1 = '0; b_rs2 = '0; b_rd = '0; b_wd = '0;
    b_we = 1'b0; b_rsv = 1'b0; b_raddr = '0;

    step();
    step();
    a_rs1 = 5'd2;
    settle();
    check("rst_ready", {63'd0, a_ready}, 64'd0);
    check("rst_data", {32'd0, a_d1}, 64'd0);

    reset_n = 1'b1;
    run_init();
    check("init_cycles_a", cnt_a, 31);
    check("init_cycles_b", cnt_b, 7);

    a_rs1 = 5'd2; a_rs2 = 5'd1;
    settle();
    check("x2_sp", {32'd0, a_d1}, 64'h0100_0000);
    check("x1_zero", {32'd0, a_d2}, 64'd0);
    check("busy_init", {62'd0, a_busy1, a_busy2}, 64'd0);
    a_rs1 = 5'd3; a_rs2 = 5'd31;
    settle();
    check("x3_x31", {a_d1, a_d2}, 64'd0);

    a_we = 1'b1; a_rd = 5'd5; a_wd = 32'hDEAD_BEEF; a_rs1 = 5'd5;
    settle();
    check("bypass", {32'd0, a_d1}, 64'hDEAD_BEEF);
    step();
    a_we = 1'b0;
    settle();
    check("x5_held", {32'd0, a_d1}, 64'hDEAD_BEEF);

    a_we = 1'b1; a_rd = 5'd0; a_wd = 32'h1234; a_rs1 = 5'd0;
    settle();
    check("x0_bypass", {32'd0, a_d1}, 64'd0);
    step();
    a_we = 1'b0;
    settle();
    check("x0_zero", {32'd0, a_d1}, 64'd0);

    a_rsv = 1'b1; a_raddr = 5'd7; a_rs2 = 5'd7;
    settle();
    check("rsv_same_cyc", {63'd0, a_busy2}, 64'd0);
    step();
    a_rsv = 1'b0;
    settle();
    check("rsv_busy", {63'd0, a_busy2}, 64'd1);
    a_we = 1'b1; a_rd = 5'd7; a_wd = 32'd9;
    settle();
    check("wb_hide_busy", {63'd0, a_busy2}, 64'd0);
    check("wb_bypass", {32'd0, a_d2}, 64'd9);
    step();
    a_we = 1'b0;
    settle();
    check("wb_cleared", {63'd0, a_busy2}, 64'd0);
    check("wb_data", {32'd0, a_d2}, 64'd9);

    a_rsv = 1'b1; a_raddr = 5'd7;
    a_we = 1'b1; a_rd = 5'd7; a_wd = 32'd3;
    step();
    a_rsv = 1'b0; a_we = 1'b0;
    settle();
    check("coll_data", {32'd0, a_d2}, 64'd3);
    check("coll_busy", {63'd0, a_busy2}, 64'd1);

    b_rs1 = 3'd3; b_rs2 = 3'd1;
    settle();
    check("b_x3_sp", b_d1, 64'h0000_0000_0100_0000);
    check("b_x1_zero", b_d2, 64'd0);
    b_we = 1'b1; b_rd = 3'd5; b_wd = 64'hFEDC_BA98_7654_3210;
    step();
    b_rd = 3'd7; b_wd = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    b_we = 1'b0; b_rs1 = 3'd5; b_rs2 = 3'd7;
    settle();
    check("b_x5_64", b_d1, 64'hFEDC_BA98_7654_3210);
    check("b_x7_ones", b_d2, 64'hFFFF_FFFF_FFFF_FFFF);

    a_rs1 = 5'd5; a_rs2 = 5'd7;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    settle();
    check("mid_ready", {63'd0, a_ready}, 64'd0);
    check("mid_data", {a_d1, 32'd0}, 64'd0);
    check("mid_busy", {63'd0, a_busy2}, 64'd0);
    a_we = 1'b1; a_rd = 5'd1; a_wd = 32'hAAAA_5555; a_rs1 = 5'd1;
    a_rsv = 1'b1; a_raddr = 5'd4;
    step();
    settle();
    check("mid_no_bypass", {32'd0, a_d1}, 64'd0);
    run_init();
    a_we = 1'b0; a_rsv = 1'b0;
    check("reinit_cycles", cnt_a + 1, 31);
    a_rs1 = 5'd1; a_rs2 = 5'd4;
    settle();
    check("x1_not_written", {32'd0, a_d1}, 64'd0);
    check("x4_not_reserved", {63'd0, a_busy2}, 64'd0);
    a_rs1 = 5'd5; a_rs2 = 5'd7;
    settle();
    check("x5_cleared", {32'd0, a_d1}, 64'd0);
    check("x7_not_busy", {63'd0, a_busy2}, 64'd0);
    a_rs1 = 5'd2;
    settle();
    check("x2_sp_again", {32'd0, a_d1}, 64'h0100_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
